// File: rtl/alu_issue.sv
// alu_issue: decode/forwarding issue stage with a two-entry skid buffer.
//
// Each accepted instruction is decoded into an ALU control code and its
// operands are resolved through the forwarding muxes at acceptance time.
// The resolved entry is then held in a main output register. A second entry
// can wait behind it in a skid register, so in_ready is a pure register
// output with no combinational path from out_ready.
//
// Ports:
//   clk                      rising-edge clock
//   reset                    synchronous reset, active-low
//   in_valid / in_ready      upstream handshake (in_ready is registered)
//   aluop, funct3, funct7b5, op5   decode fields
//   rd1, rd2, immext, alusrc regfile data, immediate, B-select (1 = imm)
//   forward_a, forward_b     00/11 regfile, 10 mem_result, 01 wb_result
//   mem_result, wb_result    forwarding sources
//   rd_in                    destination register tag
//   flush                    drop every held entry and the current input
//   out_valid / out_ready    downstream handshake
//   a, b, alucontrol, store_data, rd_out, illegal   issued entry
module alu_issue #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       aluop,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             op5,
  input  logic [WIDTH-1:0] rd1,
  input  logic [WIDTH-1:0] rd2,
  input  logic [WIDTH-1:0] immext,
  input  logic             alusrc,
  input  logic [1:0]       forward_a,
  input  logic [1:0]       forward_b,
  input  logic [WIDTH-1:0] mem_result,
  input  logic [WIDTH-1:0] wb_result,
  input  logic [4:0]       rd_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [2:0]       alucontrol,
  output logic [WIDTH-1:0] store_data,
  output logic [4:0]       rd_out,
  output logic             illegal
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] store_data;
    logic [4:0]       rd;
    logic [2:0]       alucontrol;
    logic             illegal;
  } entry_t;

  // Returns {illegal, alucontrol}.
  function automatic logic [3:0] decode_op(input logic [1:0] op,
                                           input logic [2:0] f3,
                                           input logic       o5,
                                           input logic       f7b5);
    logic [3:0] r;
    r = 4'b1000;
    case (op)
      2'b00: r = 4'b0000;
      2'b01: r = 4'b0001;
      2'b10: begin
        case (f3)
          3'b000:  r = (o5 & f7b5) ? 4'b0001 : 4'b0000;
          3'b010:  r = 4'b0101;
          3'b110:  r = 4'b0011;
          3'b111:  r = 4'b0010;
          default: r = 4'b1000;
        endcase
      end
      default: r = 4'b1000;
    endcase
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] fwd_sel(input logic [1:0]       sel,
                                               input logic [WIDTH-1:0] regv,
                                               input logic [WIDTH-1:0] memv,
                                               input logic [WIDTH-1:0] wbv);
    logic [WIDTH-1:0] r;
    case (sel)
      2'b10:   r = memv;
      2'b01:   r = wbv;
      default: r = regv;
    endcase
    return r;
  endfunction

  state_t     state;
  state_t     state_next;
  entry_t     main_q;
  entry_t     skid_q;
  entry_t     incoming;
  logic [3:0] dec;
  logic [WIDTH-1:0] fb;
  logic       in_xfer;
  logic       drain;
  logic       load_main;
  logic       load_skid;
  logic       move_skid;

  // Resolve the presented instruction into a complete entry.
  always_comb begin
    dec                 = decode_op(aluop, funct3, op5, funct7b5);
    fb                  = fwd_sel(forward_b, rd2, mem_result, wb_result);
    incoming.a          = fwd_sel(forward_a, rd1, mem_result, wb_result);
    incoming.b          = alusrc ? immext : fb;
    incoming.store_data = fb;
    incoming.rd         = rd_in;
    incoming.alucontrol = dec[2:0];
    incoming.illegal    = dec[3];
  end

  assign in_xfer = in_valid & in_ready;
  assign drain   = (state != EMPTY) & out_ready;

  // Occupancy next-state and register load selects.
  always_comb begin
    state_next = state;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    move_skid  = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            load_main  = 1'b1;
            state_next = ONE;
          end else begin
            state_next = EMPTY;
          end
        end
        ONE: begin
          if (drain) begin
            // Drain and refill in the same edge keeps occupancy at one.
            if (in_xfer) begin
              load_main  = 1'b1;
              state_next = ONE;
            end else begin
              state_next = EMPTY;
            end
          end else if (in_xfer) begin
            load_skid  = 1'b1;
            state_next = FULL;
          end else begin
            state_next = ONE;
          end
        end
        FULL: begin
          // in_ready is low here, so no input can arrive alongside the move.
          if (drain) begin
            move_skid  = 1'b1;
            state_next = ONE;
          end else begin
            state_next = FULL;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // State, handshake flags and payload registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      main_q    <= '0;
      skid_q    <= '0;
    end else begin
      state     <= state_next;
      out_valid <= (state_next != EMPTY);
      in_ready  <= (state_next != FULL);
      if (load_main) begin
        main_q <= incoming;
      end else if (move_skid) begin
        main_q <= skid_q;
      end else begin
        main_q <= main_q;
      end
      if (load_skid) begin
        skid_q <= incoming;
      end else begin
        skid_q <= skid_q;
      end
    end
  end

  assign a          = main_q.a;
  assign b          = main_q.b;
  assign store_data = main_q.store_data;
  assign rd_out     = main_q.rd;
  assign alucontrol = main_q.alucontrol;
  assign illegal    = main_q.illegal;

endmodule
